// File: rtl/sound_pkg.sv
// Shared constants for the APU frame sequencer: step schedule masks,
// length limits, channel indices and default timing.
package sound_pkg;

  localparam int CLKS_PER_STEP_DEFAULT = 64453;
  localparam int PRESCALE_W_DEFAULT    = 17;

  // Bit n set means the wrap out of step n issues that tick.
  localparam logic [7:0] LEN_STEPS   = 8'b01010101;
  localparam logic [7:0] SWEEP_STEPS = 8'b01000100;
  localparam logic [7:0] ENV_STEPS   = 8'b10000000;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  localparam int CH1 = 0;
  localparam int CH2 = 1;
  localparam int CH3 = 2;
  localparam int CH4 = 3;

  function automatic int len_max_for(input int ch);
    return (ch == CH3) ? LEN_MAX_WAVE : LEN_MAX_SQ;
  endfunction

endpackage

// File: rtl/sound_length_counter.sv
// One channel's length counter and ON flag.
// SOUND_SEQ_EXTRA_LEN_CLOCK_EN adds the extra clock on a length-enable rising edge.
module sound_length_counter
  import sound_pkg::*;
#(
  parameter int LEN_MAX = LEN_MAX_SQ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_en,
  input  logic       trigger,
  input  logic       len_load,
  input  logic [7:0] len_data,
  input  logic       len_en,
  input  logic       len_tick,
  input  logic       step_odd,
  output logic       ch_on
);

  localparam logic [8:0] LEN_MAX_V = 9'(LEN_MAX);
  localparam logic [7:0] DATA_MASK = 8'(LEN_MAX - 1);

  logic [8:0] count_reg, count_next, base;
  logic       on_reg, on_next;
  logic [8:0] load_value;
  logic       extra_clk, extra_dec;

  assign load_value = LEN_MAX_V - {1'b0, len_data & DATA_MASK};

`ifdef SOUND_SEQ_EXTRA_LEN_CLOCK_EN
  logic len_en_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) len_en_prev_reg <= 1'b0;
    else     len_en_prev_reg <= master_en & len_en;
  end

  // A load this cycle takes precedence over the edge-triggered decrement.
  assign extra_clk = len_en & ~len_en_prev_reg & step_odd & ~len_load;
`else
  logic unused_step_odd;
  assign unused_step_odd = step_odd;
  assign extra_clk       = 1'b0;
`endif

  assign extra_dec = extra_clk && (count_reg != 9'd0);

  always_comb begin
    count_next = count_reg;
    on_next    = on_reg;
    base       = len_load ? load_value : count_reg;
    count_next = extra_dec ? base - 9'd1 : base;
    if (trigger) begin
      on_next = 1'b1;
      if (count_next == 9'd0)
        count_next = extra_dec ? LEN_MAX_V - 9'd1 : LEN_MAX_V;
    end else if (extra_dec) begin
      if (count_next == 9'd0) on_next = 1'b0;
    end else if (!len_load && len_tick && len_en && count_reg != 9'd0) begin
      count_next = count_reg - 9'd1;
      if (count_next == 9'd0) on_next = 1'b0;
    end
    if (!master_en) begin
      count_next = 9'd0;
      on_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 9'd0;
      on_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      on_reg    <= on_next;
    end
  end

  assign ch_on = on_reg;

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer: prescaler, 8-step schedule, tick strobes and four
// length counters. Optional macro: SOUND_SEQ_EXTRA_LEN_CLOCK_EN.
module sound_frame_sequencer
  import sound_pkg::*;
#(
  parameter int CLKS_PER_STEP = CLKS_PER_STEP_DEFAULT,
  parameter int PRESCALE_W    = PRESCALE_W_DEFAULT
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_MASTER_EN,
  input  logic [3:0] I_TRIGGER,
  input  logic [3:0] I_LEN_LOAD,
  input  logic [7:0] I_LEN_DATA,
  input  logic [3:0] I_LEN_EN,
  output logic       O_LEN_TICK,
  output logic       O_SWEEP_TICK,
  output logic       O_ENV_TICK,
  output logic [2:0] O_STEP,
  output logic [3:0] O_CH_ON
);

  localparam logic [PRESCALE_W-1:0] TERMINAL = PRESCALE_W'(CLKS_PER_STEP - 1);

  logic [PRESCALE_W-1:0] prescale_reg;
  logic [2:0]            step_reg;
  logic                  len_tick_reg, sweep_tick_reg, env_tick_reg;
  logic [3:0]            ch_on;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      prescale_reg   <= '0;
      step_reg       <= 3'd0;
      len_tick_reg   <= 1'b0;
      sweep_tick_reg <= 1'b0;
      env_tick_reg   <= 1'b0;
    end else if (!I_MASTER_EN) begin
      prescale_reg   <= '0;
      step_reg       <= 3'd0;
      len_tick_reg   <= 1'b0;
      sweep_tick_reg <= 1'b0;
      env_tick_reg   <= 1'b0;
    end else if (prescale_reg == TERMINAL) begin
      // Ticks decode the step being left, not the one being entered.
      prescale_reg   <= '0;
      step_reg       <= step_reg + 3'd1;
      len_tick_reg   <= LEN_STEPS[step_reg];
      sweep_tick_reg <= SWEEP_STEPS[step_reg];
      env_tick_reg   <= ENV_STEPS[step_reg];
    end else begin
      prescale_reg   <= prescale_reg + 1'b1;
      len_tick_reg   <= 1'b0;
      sweep_tick_reg <= 1'b0;
      env_tick_reg   <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_ch
      sound_length_counter #(
        .LEN_MAX(len_max_for(gi))
      ) u_len (
        .clk      (I_CLK),
        .rst      (I_RESET),
        .master_en(I_MASTER_EN),
        .trigger  (I_TRIGGER[gi]),
        .len_load (I_LEN_LOAD[gi]),
        .len_data (I_LEN_DATA),
        .len_en   (I_LEN_EN[gi]),
        .len_tick (len_tick_reg),
        .step_odd (step_reg[0]),
        .ch_on    (ch_on[gi])
      );
    end
  endgenerate

  assign O_LEN_TICK   = len_tick_reg;
  assign O_SWEEP_TICK = sweep_tick_reg;
  assign O_ENV_TICK   = env_tick_reg;
  assign O_STEP       = step_reg;
  assign O_CH_ON      = ch_on;

endmodule
